// File: rtl/if_id_skid_buffer.sv
// IF->ID pipeline register built as a 2-entry skid buffer.
// Fetch sees a ready that depends only on state; decode sees a registered head entry.
module if_id_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instruction,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instruction,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] head_pc;
    logic [WIDTH-1:0] head_instruction;
    logic [WIDTH-1:0] skid_pc;
    logic [WIDTH-1:0] skid_instruction;

    logic push;
    logic pop;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push) state_next = HALF;
                HALF: begin
                    if (push && !pop) begin
                        state_next = FULL;
                    end else if (!push && pop) begin
                        state_next = EMPTY;
                    end
                end
                FULL: if (pop) state_next = HALF;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        occupancy = state;
    end

    // Head is zeroed whenever the buffer empties, so out_* reads as a bubble
    // straight from the flops without any output gating.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_pc          <= '0;
            head_instruction <= '0;
            skid_pc          <= '0;
            skid_instruction <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        head_pc          <= in_pc;
                        head_instruction <= in_instruction;
                    end
                end
                HALF: begin
                    if (push && pop) begin
                        head_pc          <= in_pc;
                        head_instruction <= in_instruction;
                    end else if (push) begin
                        skid_pc          <= in_pc;
                        skid_instruction <= in_instruction;
                    end else if (pop) begin
                        head_pc          <= '0;
                        head_instruction <= '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_pc          <= skid_pc;
                        head_instruction <= skid_instruction;
                    end
                end
                default: begin
                    head_pc          <= '0;
                    head_instruction <= '0;
                end
            endcase
        end
    end

    assign out_pc          = head_pc;
    assign out_instruction = head_instruction;

endmodule
